// File: rtl/fifo_drain_if.sv
// Drain-side bundle: fifo read port on one side, 4-phase req/ack delivery channel on the other.
// The master modport is the drain; the slave modport is the fifo plus the downstream stage.
interface fifo_drain_if #(
   parameter int SIZE             = 8,
   parameter int DESTINATION_BITS = 4
);
   logic                             fifo_empty;
   logic [SIZE-1:0]                  fifo_item;
   logic                             fifo_read;
   logic                             out_req;
   logic                             out_ack;
   logic [DESTINATION_BITS-1:0]      out_dest;
   logic [SIZE-DESTINATION_BITS-1:0] out_payload;

   modport master (
      input  fifo_empty, fifo_item, out_ack,
      output fifo_read, out_req, out_dest, out_payload
   );

   modport slave (
      output fifo_empty, fifo_item, out_ack,
      input  fifo_read, out_req, out_dest, out_payload
   );
endinterface

// File: rtl/fifo_drain.sv
// Pops one item from a router input fifo and delivers it over a 4-phase req/ack channel,
// holding the item in an output register until the handshake completes.
module fifo_drain #(
   parameter int ID               = -1,
   parameter int SIZE             = 8,
   parameter int DESTINATION_BITS = 4,
   parameter int COUNT_BITS       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fifo_drain_if.master          bus,
   output logic [COUNT_BITS-1:0] delivered_o
);

   localparam logic [1:0] IDLE    = 2'b00;
   localparam logic [1:0] REQ     = 2'b01;
   localparam logic [1:0] RELEASE = 2'b10;

   // Destination must leave at least one payload bit; ID is a debug tag and never below -1.
   if (DESTINATION_BITS < 1 || DESTINATION_BITS >= SIZE || ID < -1) begin : g_bad_cfg
      $error("fifo_drain: illegal parameter combination");
   end

   logic [1:0]            state_q, state_d;
   logic                  req_q, req_d;
   logic [SIZE-1:0]       item_q, item_d;
   logic [COUNT_BITS-1:0] delivered_q, delivered_d;
   logic                  pop;

   // A stale ack seen in IDLE blocks the pop; reset also masks it so nothing is lost while held.
   assign pop = rst_n & (state_q == IDLE) & ~bus.fifo_empty & ~bus.out_ack;

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      item_d      = item_q;
      delivered_d = delivered_q;
      case (state_q)
         IDLE: begin
            req_d = 1'b0;
            if (pop) begin
               item_d  = bus.fifo_item;
               req_d   = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            req_d = 1'b1;
            if (bus.out_ack) begin
               req_d   = 1'b0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            req_d = 1'b0;
            if (!bus.out_ack) begin
               delivered_d = delivered_q + COUNT_BITS'(1);
               state_d     = IDLE;
            end
         end
         default: begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         req_q       <= 1'b0;
         item_q      <= '0;
         delivered_q <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         item_q      <= item_d;
         delivered_q <= delivered_d;
      end
   end

   assign bus.fifo_read   = pop;
   assign bus.out_req     = req_q;
   assign bus.out_dest    = item_q[DESTINATION_BITS-1:0];
   assign bus.out_payload = item_q[SIZE-1:DESTINATION_BITS];
   assign delivered_o     = delivered_q;

endmodule
